// File: rtl/tx_ctrl_pkg.sv
// tx_ctrl_pkg: shared state/mode encodings and widths for the TX serializer sequencer.
package tx_ctrl_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD     = 3'd1,
    REL_PRBS = 3'd2,
    WARMUP   = 3'd3,
    RUN      = 3'd4
  } tx_seq_state_e;

  typedef enum logic [1:0] {
    ERR_OFF      = 2'b00,
    ERR_SINGLE   = 2'b01,
    ERR_PERIODIC = 2'b10,
    ERR_RSVD     = 2'b11
  } err_mode_e;

endpackage

// File: rtl/tx_err_sched.sv
// tx_err_sched: error-injection scheduler (single-shot / periodic) with saturating event count.
// Optional macro TX_ERR_BURST_EN stretches each event into an err_burst_len+1 cycle burst.
module tx_err_sched
  import tx_ctrl_pkg::*;
#(
  parameter int ERR_PERIOD_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clr,
  input  logic [1:0]              err_mode,
  input  logic                    err_trig,
  input  logic [ERR_PERIOD_W-1:0] err_period,
`ifdef TX_ERR_BURST_EN
  input  logic [3:0]              err_burst_len,
`endif
  output logic                    inj_error,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  err_mode_e                mode;
  logic                     trig_d_reg;
  logic [1:0]               mode_q_reg;
  logic [ERR_PERIOD_W-1:0]  period_q_reg;
  logic [ERR_PERIOD_W-1:0]  per_cnt_reg, per_cnt_next;
  logic                     inj_error_reg, inj_error_next;
  logic [ERR_CNT_W-1:0]     err_cnt_reg, err_cnt_next;
  logic                     cfg_change, period_last, per_active;
  logic                     per_hit, single_hit, event_hit, event_take;

  assign mode        = err_mode_e'(err_mode);
  assign cfg_change  = (err_mode != mode_q_reg) || (err_period != period_q_reg);
  assign per_active  = enable && !cfg_change && (mode == ERR_PERIODIC) && (err_period != '0);
  assign period_last = (per_cnt_reg == err_period - ERR_PERIOD_W'(1));
  assign per_hit     = per_active && period_last;
  assign single_hit  = enable && (mode == ERR_SINGLE) && err_trig && !trig_d_reg;
  assign event_hit   = per_hit || single_hit;

  // Counter idles at 0 outside RUN and restarts whenever the configuration moves.
  always_comb begin
    per_cnt_next = '0;
    if (per_active && !period_last)
      per_cnt_next = per_cnt_reg + ERR_PERIOD_W'(1);
  end

`ifdef TX_ERR_BURST_EN
  logic [3:0] burst_reg, burst_next;

  // While a burst is draining, fresh events are swallowed and not counted.
  always_comb begin
    burst_next     = '0;
    inj_error_next = 1'b0;
    event_take     = 1'b0;
    if (enable) begin
      if (burst_reg != '0) begin
        inj_error_next = 1'b1;
        burst_next     = burst_reg - 4'd1;
      end else if (event_hit) begin
        inj_error_next = 1'b1;
        burst_next     = err_burst_len;
        event_take     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) burst_reg <= '0;
    else     burst_reg <= burst_next;
  end
`else
  assign inj_error_next = event_hit;
  assign event_take     = event_hit;
`endif

  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (clr)
      err_cnt_next = '0;
    else if (event_take && (err_cnt_reg != '1))
      err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_d_reg    <= 1'b0;
      mode_q_reg    <= '0;
      period_q_reg  <= '0;
      per_cnt_reg   <= '0;
      inj_error_reg <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      trig_d_reg    <= err_trig;
      mode_q_reg    <= err_mode;
      period_q_reg  <= err_period;
      per_cnt_reg   <= per_cnt_next;
      inj_error_reg <= inj_error_next;
      err_cnt_reg   <= err_cnt_next;
    end
  end

  assign inj_error = inj_error_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: rtl/tx_prbs_seq_ctrl.sv
// tx_prbs_seq_ctrl: orders PRBS/mux reset release for the TX serializer and gates error injection to RUN.
// Optional macro TX_ERR_BURST_EN adds the err_burst_len input for multi-cycle injection bursts.
module tx_prbs_seq_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYC = 16,
  parameter int MUX_DLY_CYC  = 4,
  parameter int WARMUP_CYC   = 64,
  parameter int ERR_PERIOD_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              err_mode,
  input  logic                    err_trig,
  input  logic [ERR_PERIOD_W-1:0] err_period,
`ifdef TX_ERR_BURST_EN
  input  logic [3:0]              err_burst_len,
`endif
  output logic                    rst_prbs,
  output logic                    rst_mux,
  output logic                    inj_error,
  output logic                    tx_ready,
  output logic [2:0]              state_o,
  output logic [ERR_CNT_W-1:0]    err_cnt
);

  localparam int PH_A   = (RST_HOLD_CYC > MUX_DLY_CYC) ? RST_HOLD_CYC : MUX_DLY_CYC;
  localparam int PH_MAX = (PH_A > WARMUP_CYC) ? PH_A : WARMUP_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  tx_seq_state_e   state_reg, state_next;
  logic [PH_W-1:0] ph_cnt_reg, ph_cnt_next;
  logic            rst_prbs_reg, rst_mux_reg, tx_ready_reg;
  logic            clr_cnt, run_en;

  always_comb begin
    state_next  = state_reg;
    ph_cnt_next = '0;
    clr_cnt     = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = HOLD;
            clr_cnt    = 1'b1;
          end
        end
        HOLD: begin
          if (ph_cnt_reg == PH_W'(RST_HOLD_CYC - 1)) state_next  = REL_PRBS;
          else                                       ph_cnt_next = ph_cnt_reg + PH_W'(1);
        end
        REL_PRBS: begin
          if (ph_cnt_reg == PH_W'(MUX_DLY_CYC - 1)) state_next  = WARMUP;
          else                                      ph_cnt_next = ph_cnt_reg + PH_W'(1);
        end
        WARMUP: begin
          if (ph_cnt_reg == PH_W'(WARMUP_CYC - 1)) state_next  = RUN;
          else                                     ph_cnt_next = ph_cnt_reg + PH_W'(1);
        end
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ph_cnt_reg   <= '0;
      rst_prbs_reg <= 1'b1;
      rst_mux_reg  <= 1'b1;
      tx_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ph_cnt_reg   <= ph_cnt_next;
      rst_prbs_reg <= (state_next == IDLE) || (state_next == HOLD);
      rst_mux_reg  <= !((state_next == WARMUP) || (state_next == RUN));
      tx_ready_reg <= (state_next == RUN);
    end
  end

  assign run_en = (state_next == RUN);

  tx_err_sched #(
    .ERR_PERIOD_W (ERR_PERIOD_W)
  ) u_err_sched (
    .clk           (clk),
    .rst           (rst),
    .enable        (run_en),
    .clr           (clr_cnt),
    .err_mode      (err_mode),
    .err_trig      (err_trig),
    .err_period    (err_period),
`ifdef TX_ERR_BURST_EN
    .err_burst_len (err_burst_len),
`endif
    .inj_error     (inj_error),
    .err_cnt       (err_cnt)
  );

  assign rst_prbs = rst_prbs_reg;
  assign rst_mux  = rst_mux_reg;
  assign tx_ready = tx_ready_reg;
  assign state_o  = state_reg;

endmodule

// File: tb/tb_tx_prbs_seq_ctrl.sv
// tb_tx_prbs_seq_ctrl: directed bench for the TX bring-up sequencer with a timeline-based model.
// Define TX_ERR_BURST_EN for bench and RTL together to cover burst injection.
module tb_tx_prbs_seq_ctrl;

  localparam int HOLD_C = 16;
  localparam int DLY_C  = 4;
  localparam int WARM_C = 64;
  localparam int PW     = 16;
  localparam int T_REL  = HOLD_C;
  localparam int T_WARM = HOLD_C + DLY_C;
  localparam int T_RUN  = HOLD_C + DLY_C + WARM_C;

  logic          clk        = 1'b0;
  logic          rst        = 1'b0;
  logic          start      = 1'b0;
  logic          stop       = 1'b0;
  logic          err_trig   = 1'b0;
  logic [1:0]    err_mode   = 2'b00;
  logic [PW-1:0] err_period = '0;
`ifdef TX_ERR_BURST_EN
  logic [3:0]    err_burst_len = 4'd0;
`endif
  logic          rst_prbs, rst_mux, inj_error, tx_ready;
  logic [2:0]    state_o;
  logic [15:0]   err_cnt;

  always #5 clk = ~clk;

  tx_prbs_seq_ctrl #(
    .RST_HOLD_CYC (HOLD_C),
    .MUX_DLY_CYC  (DLY_C),
    .WARMUP_CYC   (WARM_C),
    .ERR_PERIOD_W (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .err_mode      (err_mode),
    .err_trig      (err_trig),
    .err_period    (err_period),
`ifdef TX_ERR_BURST_EN
    .err_burst_len (err_burst_len),
`endif
    .rst_prbs      (rst_prbs),
    .rst_mux       (rst_mux),
    .inj_error     (inj_error),
    .tx_ready      (tx_ready),
    .state_o       (state_o),
    .err_cnt       (err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: elapsed cycles since the start edge decide the phase; injections from RUN-cycle index.
  int cyc = 0;
  int m_t = 0;
  int m_run_k = 0;
  int m_cnt = 0;
  int m_burst_left = 0;
  bit m_active = 1'b0;
  bit m_prev_trig = 1'b0;
  bit m_inj = 1'b0;

  function automatic int exp_state();
    if (!m_active)        return 0;
    if (m_t < T_REL)      return 1;
    if (m_t < T_WARM)     return 2;
    if (m_t < T_RUN)      return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_t = 0; m_run_k = 0; m_cnt = 0;
    m_burst_left = 0; m_prev_trig = 1'b0; m_inj = 1'b0;
  endtask

  task automatic model_edge();
    bit ev;
    cyc++;
    if (stop) m_active = 1'b0;
    else if (!m_active) begin
      if (start) begin m_active = 1'b1; m_t = 0; m_cnt = 0; end
    end else if (m_t < T_RUN) m_t++;
    m_inj = 1'b0;
    ev = 1'b0;
    if (exp_state() == 4) begin
      m_run_k++;
      if (err_mode == 2'b10 && err_period != 0 && (m_run_k % int'(err_period)) == 0) ev = 1'b1;
      if (err_mode == 2'b01 && err_trig && !m_prev_trig) ev = 1'b1;
`ifdef TX_ERR_BURST_EN
      if (m_burst_left > 0) begin
        m_inj = 1'b1; m_burst_left--;
      end else if (ev) begin
        m_inj = 1'b1; m_burst_left = int'(err_burst_len);
        if (m_cnt < 65535) m_cnt++;
      end
`else
      if (ev) begin
        m_inj = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
`endif
    end else begin
      m_run_k = 0;
      m_burst_left = 0;
    end
    m_prev_trig = err_trig;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s @edge %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("state_o",   state_o,   exp_state());
    chk("rst_prbs",  rst_prbs,  exp_state() <= 1);
    chk("rst_mux",   rst_mux,   exp_state() <= 2);
    chk("tx_ready",  tx_ready,  exp_state() == 4);
    chk("inj_error", inj_error, m_inj);
    chk("err_cnt",   err_cnt,   m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_state"},    state_o,   0);
    chk({tag, "_rst_prbs"}, rst_prbs,  1);
    chk({tag, "_rst_mux"},  rst_mux,   1);
    chk({tag, "_tx_ready"}, tx_ready,  0);
    chk({tag, "_inj"},      inj_error, 0);
  endtask

  task automatic stop_now(input string tag);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle_outputs(tag);
  endtask

  // Start pulse sampled in cycle 0; returns at the first RUN cycle (cycle 85).
  task automatic run_bringup(input int trig_at);
    int f_prbs, f_mux, f_rdy, rel, cnt_at1;
    logic [2:0] last;
    int walk[$];
    f_prbs = 0; f_mux = 0; f_rdy = 0; rel = 0; cnt_at1 = -1;
    last = state_o;
    walk.push_back(int'(state_o));
    start = 1'b1;
    while (rel < 120) begin
      step();
      rel++;
      start = 1'b0;
      if (rel == 1) cnt_at1 = int'(err_cnt);
      if (state_o != last) begin walk.push_back(int'(state_o)); last = state_o; end
      if (f_prbs == 0 && rst_prbs == 1'b0) f_prbs = rel;
      if (f_mux == 0 && rst_mux == 1'b0) f_mux = rel;
      if (tx_ready == 1'b1) begin f_rdy = rel; break; end
      err_trig = (rel == trig_at);
    end
    err_trig = 1'b0;
    chk("prbs_release_cycle", f_prbs, 17);
    chk("mux_release_cycle",  f_mux,  21);
    chk("tx_ready_cycle",     f_rdy,  85);
    chk("err_cnt_cleared",    cnt_at1, 0);
    chk("state_walk_len",     walk.size(), 5);
    for (int i = 0; i < walk.size() && i < 5; i++) chk("state_walk", walk[i], i);
    $display("[tb] bring-up: prbs@%0d mux@%0d ready@%0d", f_prbs, f_mux, f_rdy);
  endtask

  task automatic run_window(input int n, output int high, output int first);
    high = 0; first = 0;
    for (int i = 1; i <= n; i++) begin
      if (i > 1) step();
      if (inj_error) begin
        high++;
        if (first == 0) first = i;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, first;
    #1 rst = 1'b1;
    model_reset();
    #1;
    check_idle_outputs("reset");
    chk("reset_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();

    // Periodic, period 5
    err_mode = 2'b10; err_period = 16'd5;
    step();
    run_bringup(0);
    run_window(20, hi, first);
    chk("periodic_first_idx", first, 5);
    chk("periodic_pulses",    hi,    4);
    chk("periodic_err_cnt",   err_cnt, 4);
    $display("[tb] periodic p=5: first=%0d pulses=%0d err_cnt=%0d", first, hi, err_cnt);
    repeat (4) step();
    stop_now("stop_run");
    chk("stop_run_keeps_cnt", err_cnt, 4);
    step();

    // Single-shot with a dropped edge during WARMUP
    err_mode = 2'b01;
    step();
    run_bringup(40);
    hi = 0;
    for (int i = 0; i < 22; i++) begin
      err_trig = (i < 10 || i == 15);
      step();
      if (inj_error) hi++;
    end
    err_trig = 1'b0;
    chk("single_pulses",  hi, 2);
    chk("single_err_cnt", err_cnt, 2);
    $display("[tb] single-shot: pulses=%0d err_cnt=%0d", hi, err_cnt);
    stop_now("stop_single");

    // Stop in WARMUP
    start = 1'b1; step(); start = 1'b0;
    repeat (29) step();
    chk("warmup_state", state_o, 3);
    stop_now("stop_warmup");
    $display("[tb] stop in WARMUP done");
    repeat (3) step();

    // Period 1 pulses every RUN cycle
    err_mode = 2'b10; err_period = 16'd1;
    step();
    run_bringup(0);
    run_window(10, hi, first);
    chk("p1_first_idx", first, 1);
    chk("p1_pulses",    hi, 10);
    chk("p1_err_cnt",   err_cnt, 10);
    $display("[tb] periodic p=1: pulses=%0d err_cnt=%0d", hi, err_cnt);
    stop_now("stop_p1");

    // Period 0 and reserved mode never inject
    err_period = 16'd0;
    step();
    run_bringup(0);
    run_window(20, hi, first);
    chk("p0_pulses", hi, 0);
    chk("p0_err_cnt", err_cnt, 0);
    stop_now("stop_p0");
    err_mode = 2'b11; err_period = 16'd5;
    step();
    run_bringup(0);
    run_window(20, hi, first);
    chk("rsvd_pulses", hi, 0);
    $display("[tb] period 0 / reserved mode: no pulses");
    stop_now("stop_rsvd");

    // Async reset between edges during REL_PRBS
    err_mode = 2'b10; err_period = 16'd5;
    start = 1'b1; step(); start = 1'b0;
    repeat (17) step();
    chk("relprbs_state", state_o, 2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_idle_outputs("async_rst");
    chk("async_rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) step();
    chk("after_rst_idle", state_o, 0);
    $display("[tb] async reset mid REL_PRBS done");

`ifdef TX_ERR_BURST_EN
    // Burst of 4 every 10 cycles
    err_period = 16'd10; err_burst_len = 4'd3;
    step();
    run_bringup(0);
    run_window(43, hi, first);
    chk("burst_first_idx", first, 10);
    chk("burst_high_cycles", hi, 16);
    chk("burst_err_cnt", err_cnt, 4);
    $display("[tb] burst len=3 p=10: high=%0d err_cnt=%0d", hi, err_cnt);
    stop_now("stop_burst");
    err_period = 16'd0;
    step();
    run_bringup(0);
    run_window(20, hi, first);
    chk("burst_p0_pulses", hi, 0);
    stop_now("stop_burst_p0");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_prbs_seq_ctrl.md
Name: tx_prbs_seq_ctrl

Overview:
Sequencer for the TX serializer datapath: the 16-lane PRBS generators, the 16:4 half-rate muxes and the 4:1 quarter-rate muxes.
- Runs on the PRBS-generator clock.
- Orders reset release: PRBS first, muxes after a programmable delay, then a warm-up window before asserting tx_ready.
- Schedules error injection (single-shot or periodic) onto the shared inj_error net and counts injected errors.

Parameters:
RST_HOLD_CYC, 16, cycles both resets held after start (>=1)
MUX_DLY_CYC, 4, cycles between rst_prbs release and rst_mux release (>=1)
WARMUP_CYC, 64, cycles after rst_mux release before tx_ready (>=1)
ERR_PERIOD_W, 16, width of periodic-injection period

Ports:
clk  in  1  PRBS-generator clock; single clock domain
rst  in  1  asynchronous, active-high reset
start  in  1  level; begins bring-up when in IDLE
stop  in  1  level; aborts to IDLE from any state, priority over start
err_mode  in  2  00 off, 01 single-shot, 10 periodic, 11 reserved (treated as off)
err_trig  in  1  single-shot trigger; rising edge used
err_period  in  ERR_PERIOD_W  periodic interval in cycles; 0 = no injection
rst_prbs  out  1  reset to PRBS generators, active-high
rst_mux  out  1  reset to 16:4 and 4:1 muxes, active-high
inj_error  out  1  error-inject strobe to all PRBS generators
tx_ready  out  1  datapath streaming valid pattern
state_o  out  3  current FSM state encoding
err_cnt  out  16  saturating count of injection events

Behaviour:
- All outputs are registered.
- Reset values: rst_prbs=1, rst_mux=1, inj_error=0, tx_ready=0, state_o=IDLE, err_cnt=0, internal counters=0, err_trig edge register=0.
- FSM states: IDLE=0, HOLD=1, REL_PRBS=2, WARMUP=3, RUN=4.
- IDLE: both resets high.
  - start=1 & stop=0 -> HOLD next cycle.
  - err_cnt cleared on this transition.
- HOLD: both resets high for exactly RST_HOLD_CYC cycles -> REL_PRBS.
- REL_PRBS: rst_prbs=0, rst_mux=1 for MUX_DLY_CYC cycles -> WARMUP.
- WARMUP: both resets 0 for WARMUP_CYC cycles -> RUN.
- RUN: tx_ready=1; stays until stop.
- stop=1 in any state -> IDLE next cycle:
  - rst_prbs, rst_mux high on that same next edge.
  - tx_ready and inj_error 0 on that edge.
  - In-flight count discarded.
- start held high in RUN is ignored. After a stop, start=1 with stop=0 restarts full bring-up.
- Async rst mid-sequence forces reset values immediately; bring-up restarts only on a new start.
- Error injection is active only in RUN; inj_error is forced 0 elsewhere.
  - Single-shot: one 1-cycle pulse, one cycle after each err_trig 0->1 edge seen in RUN. Edges seen outside RUN are dropped.
  - Periodic: counter runs 0..err_period-1 from RUN entry; pulse when counter==err_period-1, then wrap to 0.
  - err_period=1 gives a pulse every cycle; err_period=0 gives no pulses and holds the counter at 0.
  - err_mode or err_period change: counter restarts at 0 next cycle.
- err_cnt increments once per injection event and saturates at 16'hFFFF.

Optional Feature:
TX_ERR_BURST_EN
- Enabled: adds input err_burst_len[3:0]. Each injection event holds inj_error high for err_burst_len+1 consecutive cycles.
  - New events arriving during a burst are ignored and not counted.
  - Periodic counter keeps running during a burst.
  - stop or rst truncates the burst.
- Disabled: port absent; every event is a single-cycle pulse.

Decomposition:
- Package tx_ctrl_pkg holds:
  - enum tx_seq_state_e (IDLE..RUN, 3 bits).
  - enum err_mode_e (OFF, SINGLE, PERIODIC, RSVD).
  - localparam ERR_CNT_W=16.
- Sub-module tx_err_sched holds the injection logic: edge detect, period counter, optional burst, err_cnt.
  - Inputs: enable (=RUN) and the err_* ports.
  - Outputs: inj_error, err_cnt.
- tx_prbs_seq_ctrl holds the FSM and phase counters.

Test Plan:
- Defaults, start pulse at cycle 0:
  - rst_prbs falls at cycle 17, rst_mux at 21, tx_ready rises at 85.
  - state_o walks 0,1,2,3,4.
- RUN, err_mode=10, err_period=5 -> inj_error pulses every 5th cycle, first on the 5th RUN cycle; after 20 cycles err_cnt=4.
- RUN, err_mode=01, err_trig held high 10 cycles then low, then pulsed again -> exactly 2 single-cycle pulses; err_cnt=2. err_trig edge during WARMUP -> no pulse.
- stop asserted in WARMUP and separately in RUN mid-period -> next cycle both resets high, tx_ready=0, inj_error=0, state_o=0. A later start repeats the full 85-cycle bring-up and clears err_cnt.
- Async rst asserted mid-REL_PRBS between clock edges -> outputs reach reset values without a clock edge; no advance until a new start.
- With TX_ERR_BURST_EN, err_burst_len=3, err_period=10 -> inj_error high 4 cycles out of every 10; err_cnt counts bursts. err_period=0 -> inj_error stays 0.
